// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped 4-digit multiplexed 7-segment scanner with PWM, blanking, dp and blink
module seg7_scan_ctrl #(
  parameter logic [14:0] BASE_ADDR  = 15'h0098,
  parameter logic [15:0] SCAN_DIV   = 16'd3125,
  parameter int          BLINK_LOG2 = 6
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [3:0]  seg_sel,
  output logic [7:0]  seg_hex
);
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic        sel, en, tick, wrap, lit;
  logic [1:0]  ra, idx;
  logic [3:0]  phase;
  logic [15:0] wm, data, ctrl, raw01, raw23, sh_data, sh_raw01, sh_raw23, scan_cnt;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic [7:0]  raw_byte, base_pat, pattern;
  logic [3:0]  dp, den, bright;
  assign sel    = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
  assign ra     = per_addr[1:0];
  assign wm     = {{8{sel & per_we[1]}}, {8{sel & per_we[0]}}};
  assign en     = ctrl[0];
  assign dp     = ctrl[7:4];
  assign den    = ctrl[11:8];
  assign bright = ctrl[15:12];
  assign tick   = scan_cnt == SCAN_DIV - 16'd1;
  assign wrap   = en & tick & (phase == 4'hF) & (idx == 2'd3);
  always_comb begin
    per_dout = (sel & (per_we == 2'b00)) ?
               (ra == 2'd0 ? data : ra == 2'd1 ? ctrl : ra == 2'd2 ? raw01 : raw23) : 16'h0000;
    raw_byte = idx[1] ? (idx[0] ? sh_raw23[15:8] : sh_raw23[7:0])
                      : (idx[0] ? sh_raw01[15:8] : sh_raw01[7:0]);
    base_pat = ctrl[1] ? raw_byte : HEX[sh_data[{idx, 2'b00} +: 4]];
    pattern  = {base_pat[7] & ~dp[idx], base_pat[6:0]};
    lit      = en & den[idx] & (phase <= bright) & ~(ctrl[2] & frame_cnt[BLINK_LOG2-1]);
  end
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      data  <= 16'h0000;
      ctrl  <= 16'hFF01;
      raw01 <= 16'hFFFF;
      raw23 <= 16'hFFFF;
    end else begin
      if (ra == 2'd0) data  <= (data  & ~wm) | (per_din & wm);
      if (ra == 2'd1) ctrl  <= ((ctrl & ~wm) | (per_din & wm)) & 16'hFFF7;
      if (ra == 2'd2) raw01 <= (raw01 & ~wm) | (per_din & wm);
      if (ra == 2'd3) raw23 <= (raw23 & ~wm) | (per_din & wm);
    end
  end
  // shadows decouple display from bus writes so a frame never tears
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      sh_data  <= 16'h0000;
      sh_raw01 <= 16'hFFFF;
      sh_raw23 <= 16'hFFFF;
    end else if (wrap | ~en) begin
      sh_data  <= data;
      sh_raw01 <= raw01;
      sh_raw23 <= raw23;
    end
  end
  always_ff @(posedge mclk) begin
    if (puc_rst | ~en) begin
      scan_cnt  <= 16'd0;
      phase     <= 4'd0;
      idx       <= 2'd0;
      frame_cnt <= '0;
    end else begin
      scan_cnt <= tick ? 16'd0 : scan_cnt + 16'd1;
      if (tick) phase <= phase + 4'd1;
      if (tick & (phase == 4'hF)) idx <= idx + 2'd1;
      if (wrap) frame_cnt <= frame_cnt + 1'b1;
    end
  end
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      seg_sel <= 4'hF;
      seg_hex <= 8'hFF;
    end else begin
      seg_sel <= lit ? ~(4'b0001 << idx) : 4'hF;
      seg_hex <= lit ? pattern : 8'hFF;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scoreboard bench with a time-based display reference model
module tb_seg7_scan_ctrl;
  localparam int D = 2;
  localparam int BL = 2;
  localparam int F = 64 * D;
  localparam logic [13:0] WB = 14'h004C;
  logic        mclk = 1'b0, puc_rst = 1'b1, per_en = 1'b0;
  logic [13:0] per_addr = 14'h0;
  logic [15:0] per_din = 16'h0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_hex;
  int tests = 0, errors = 0;
  logic [11:0] out_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  lut[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [15:0] m_data, m_ctrl, m_raw01, m_raw23, s_data, s_raw01, s_raw23;
  longint t = 0;

  seg7_scan_ctrl #(.BASE_ADDR(15'h0098), .SCAN_DIV(16'(D)), .BLINK_LOG2(BL)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
    .seg_sel(seg_sel), .seg_hex(seg_hex)
  );

  always #5 mclk = ~mclk;

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] we);
    return {we[1] ? d[15:8] : o[15:8], we[0] ? d[7:0] : o[7:0]};
  endfunction

  // reference model: digit, phase and frame derived arithmetically from cycles since enable
  always @(posedge mclk) begin
    int idx, ph, fr;
    logic lit, wrap;
    logic [7:0] pat;
    logic [15:0] rw;
    if (puc_rst) begin
      out_q.push_back(12'hFFF);
      m_data = 16'h0000; m_ctrl = 16'hFF01; m_raw01 = 16'hFFFF; m_raw23 = 16'hFFFF;
      s_data = 16'h0000; s_raw01 = 16'hFFFF; s_raw23 = 16'hFFFF;
      t = 0;
    end else begin
      idx = int'((t / (16 * D)) % 4);
      ph  = int'((t / D) % 16);
      fr  = int'((t / F) % (1 << BL));
      lit = m_ctrl[0] && m_ctrl[8 + idx] && (ph <= int'(m_ctrl[15:12]))
            && !(m_ctrl[2] && fr >= (1 << (BL - 1)));
      rw  = idx < 2 ? s_raw01 : s_raw23;
      pat = m_ctrl[1] ? ((idx % 2 == 1) ? rw[15:8] : rw[7:0]) : lut[(s_data >> (4 * idx)) & 16'hF];
      if (m_ctrl[4 + idx]) pat = pat & 8'h7F;
      out_q.push_back(lit ? {~(4'b0001 << idx), pat} : 12'hFFF);
      wrap = m_ctrl[0] && (t % F == F - 1);
      if (wrap || !m_ctrl[0]) begin
        s_data = m_data; s_raw01 = m_raw01; s_raw23 = m_raw23;
      end
      t = m_ctrl[0] ? t + 1 : 0;
      if (per_en && per_addr[13:2] == WB[13:2] && per_we != 2'b00) begin
        case (per_addr[1:0])
          2'd0: m_data  = merge(m_data, per_din, per_we);
          2'd1: m_ctrl  = merge(m_ctrl, per_din, per_we) & 16'hFFF7;
          2'd2: m_raw01 = merge(m_raw01, per_din, per_we);
          default: m_raw23 = merge(m_raw23, per_din, per_we);
        endcase
      end
    end
  end

  always @(negedge mclk) begin
    logic [11:0] e;
    logic [15:0] r;
    if (out_q.size() > 0) begin
      e = out_q.pop_front();
      tests++;
      if ({seg_sel, seg_hex} !== e) begin
        errors++;
        $display("FAIL seg @%0t: got sel=%h hex=%h, expected sel=%h hex=%h", $time, seg_sel, seg_hex, e[11:8], e[7:0]);
      end
    end
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      tests++;
      if (per_dout !== r) begin
        errors++;
        $display("FAIL per_dout @%0t: got %h, expected %h", $time, per_dout, r);
      end
    end
    if (!$isunknown(seg_sel))
      assert ($countones(~seg_sel) <= 1) else $error("multiple digits selected: %b", seg_sel);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge mclk); #2;
      per_en = 1'b0; per_we = 2'b00;
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [15:0] d, input logic [1:0] we = 2'b11);
    @(posedge mclk); #2;
    per_en = 1'b1; per_addr = WB + 14'(r); per_we = we; per_din = d;
    rd_q.push_back(16'h0000);
  endtask

  task automatic rd(input logic [1:0] r);
    @(posedge mclk); #2;
    per_en = 1'b1; per_addr = WB + 14'(r); per_we = 2'b00;
    rd_q.push_back(r == 0 ? m_data : r == 1 ? m_ctrl : r == 2 ? m_raw01 : m_raw23);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge mclk);
    #2 puc_rst = 1'b0;
    for (int i = 0; i < 4; i++) rd(2'(i));
    step(20);
    // hex scan from a fresh frame
    wr(1, 16'hFF00); wr(0, 16'h3A5F); wr(1, 16'hFF01);
    step(F + 10);
    // shadowing: update data mid-frame while digit 1 is lit
    n = 0;
    while (!(m_ctrl[0] && ((t / (16 * D)) % 4) == 1) && n < 400) begin step(); n++; end
    if (n >= 400) begin
      tests++; errors++;
      $display("FAIL wait_digit1: got timeout after %0d cycles, expected digit 1 lit", n);
    end
    wr(0, 16'h1111);
    step(2 * F);
    // raw patterns, dp and digit mask
    wr(1, 16'hF542); wr(1, 16'hF543); wr(2, 16'h12C0);
    step(2 * F);
    rd(2);
    // brightness 3
    wr(1, 16'h3F01);
    step(F + 5);
    // byte write
    wr(0, 16'h1234); wr(0, 16'hABCD, 2'b01); rd(0);
    wr(0, 16'h00EF, 2'b10); rd(0);
    // enable clear then blink
    wr(1, 16'hFF00); step(5);
    wr(1, 16'hFF05); step(5 * F);
    // randomized bus traffic, including off-address and disabled accesses
    for (int i = 0; i < 60; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0, 1: wr(r, 16'($urandom), 2'($urandom_range(1, 3)));
        2: rd(r);
        3: begin
          @(posedge mclk); #2;
          per_en = 1'b1; per_addr = (WB + 14'(r)) ^ (14'h4 << $urandom_range(0, 11));
          per_we = 2'b11; per_din = 16'($urandom);
          rd_q.push_back(16'h0000);
        end
        4: wr(1, {16'($urandom)} | 16'h0001);
        default: begin
          @(posedge mclk); #2;
          per_en = 1'b0; per_addr = WB + 14'(r); per_we = 2'b00;
          rd_q.push_back(16'h0000);
        end
      endcase
      step($urandom_range(0, 150));
    end
    for (int i = 0; i < 4; i++) rd(2'(i));
    // reset mid-slot
    wr(1, 16'hFF01); step(F / 2 + 3);
    puc_rst = 1'b1; step(2);
    puc_rst = 1'b0; step(F + 4);
    for (int i = 0; i < 4; i++) rd(2'(i));
    step(3);
    @(negedge mclk); @(negedge mclk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
